// File: rtl/spi_cmd_receiver.sv
// SPI command receiver: synchronizes sclk/mosi/cs_n into clk_sys and deframes fixed-length,
// MSB-first frames into an opcode/payload pair with a one-cycle valid or error pulse.
module spi_cmd_receiver #(
    parameter int unsigned FRAME_BITS  = 35,
    parameter int unsigned OPCODE_W    = 3,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned PAYLOAD_W  = FRAME_BITS - OPCODE_W
) (
    input  logic                 i_clk_sys,
    input  logic                 i_rst,
    input  logic                 i_sclk,
    input  logic                 i_mosi,
    input  logic                 i_cs_n,
    output logic                 o_cmd_valid,
    output logic [OPCODE_W-1:0]  o_cmd_opcode,
    output logic [PAYLOAD_W-1:0] o_cmd_payload,
    output logic                 o_frame_err,
    output logic                 o_running,
    output logic                 o_busy
);

    localparam logic [6:0]          CNT_FRAME = 7'(FRAME_BITS);
    localparam logic [6:0]          CNT_MAX   = 7'(FRAME_BITS + 1);
    localparam logic [OPCODE_W-1:0] OP_RUN    = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_STOP   = OPCODE_W'(6);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
    logic                   r_sclk_prev, r_cs_prev;
    state_e                 r_state, w_state_nxt;
    logic [6:0]             r_count, w_count_nxt;
    logic [FRAME_BITS-1:0]  r_shift, w_shift_nxt;
    logic                   r_cmd_valid, w_valid_nxt;
    logic                   r_frame_err, w_err_nxt;
    logic [OPCODE_W-1:0]    r_opcode, w_opcode_nxt;
    logic [PAYLOAD_W-1:0]   r_payload, w_payload_nxt;
    logic                   r_running, w_running_nxt;

    logic w_sclk_s, w_mosi_s, w_cs_s;
    logic w_sclk_fall, w_cs_fall, w_cs_rise;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;
    assign w_cs_fall   = r_cs_prev & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_prev & w_cs_s;

    // cs_n chain and its history reset high so a still-low cs_n after reset reads as a new frame
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_shift     <= '0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_opcode    <= OP_STOP;
            r_payload   <= '0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_shift     <= w_shift_nxt;
            r_cmd_valid <= w_valid_nxt;
            r_frame_err <= w_err_nxt;
            r_opcode    <= w_opcode_nxt;
            r_payload   <= w_payload_nxt;
            r_running   <= w_running_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_shift_nxt   = r_shift;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        w_opcode_nxt  = r_opcode;
        w_payload_nxt = r_payload;
        w_running_nxt = r_running;

        if (r_cmd_valid) begin
            if (r_opcode == OP_RUN) begin
                w_running_nxt = 1'b1;
            end else if (r_opcode == OP_STOP) begin
                w_running_nxt = 1'b0;
            end
        end

        case (r_state)
            StIdle: begin
                if (w_cs_fall) begin
                    w_state_nxt = StShift;
                    w_count_nxt = '0;
                end
            end
            StShift: begin
                // A falling sclk seen together with the cs_n rise still belongs to this frame
                if (w_sclk_fall) begin
                    w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_mosi_s};
                    if (r_count != CNT_MAX) begin
                        w_count_nxt = r_count + 7'd1;
                    end
                end
                if (w_cs_rise) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (r_count == CNT_FRAME) begin
                    w_valid_nxt   = 1'b1;
                    w_opcode_nxt  = r_shift[FRAME_BITS-1 -: OPCODE_W];
                    w_payload_nxt = r_shift[PAYLOAD_W-1:0];
                end else begin
                    w_err_nxt = 1'b1;
                end
                if (w_cs_fall) begin
                    w_state_nxt = StShift;
                    w_count_nxt = '0;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign o_cmd_valid   = r_cmd_valid;
    assign o_frame_err   = r_frame_err;
    assign o_cmd_opcode  = r_opcode;
    assign o_cmd_payload = r_payload;
    assign o_running     = r_running;
    assign o_busy        = ~w_cs_s;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Directed bench for spi_cmd_receiver: bit-bangs SPI frames (sclk = clk_sys/8) and checks
// pulses, latency, held outputs, running status and reset-in-frame recovery.
module tb_spi_cmd_receiver;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic        cmd_valid, frame_err, running, busy;
    logic [2:0]  cmd_opcode;
    logic [31:0] cmd_payload;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_valid = 0;
    int n_err  = 0;
    int n_both = 0;
    logic [31:0] q_pay[$];
    logic [2:0]  q_op[$];

    spi_cmd_receiver #(
        .FRAME_BITS  (35),
        .OPCODE_W    (3),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk_sys     (clk),
        .i_rst         (rst),
        .i_sclk        (sclk),
        .i_mosi        (mosi),
        .i_cs_n        (cs_n),
        .o_cmd_valid   (cmd_valid),
        .o_cmd_opcode  (cmd_opcode),
        .o_cmd_payload (cmd_payload),
        .o_frame_err   (frame_err),
        .o_running     (running),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (cmd_valid) begin
            n_valid++;
            q_pay.push_back(cmd_payload);
            q_op.push_back(cmd_opcode);
        end
        if (frame_err) n_err++;
        if (cmd_valid && frame_err) n_both++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        tick(1);
        cs_n = 1'b0;
        tick(3);
    endtask

    task automatic end_frame();
        tick(4);
        cs_n = 1'b1;
    endtask

    // Optionally raise cs_n on the very edge that drops sclk for the last bit
    task automatic send_bits(input logic [63:0] data, input int n, input bit last_with_cs);
        for (int i = n - 1; i >= 0; i--) begin
            tick(1);
            mosi = data[i];
            tick(3);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
            if (i == 0 && last_with_cs) cs_n = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        tick(3);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
        n_cmp++; if (cmd_opcode !== 3'b110) begin n_bad++; $display("FAIL reset_opcode: got %b want 110", cmd_opcode); end
        n_cmp++; if (cmd_payload !== 32'h0) begin n_bad++; $display("FAIL reset_payload: got %h want 0", cmd_payload); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_legal_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        start_frame();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_frame: got %b want 1", busy); end
        send_bits(64'({3'b100, 32'h0001_0000}), 35, 1'b0);
        end_frame();
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (cmd_valid !== (k == 4)) begin
                n_bad++;
                $display("FAIL latency_k%0d: got %b want %b", k, cmd_valid, (k == 4));
            end
        end
        tick(12);
        n_cmp++; if (n_valid - v0 != 1) begin n_bad++; $display("FAIL legal_valid_cnt: got %0d want 1", n_valid - v0); end
        n_cmp++; if (n_err - e0 != 0) begin n_bad++; $display("FAIL legal_err_cnt: got %0d want 0", n_err - e0); end
        n_cmp++; if (cmd_opcode !== 3'b100) begin n_bad++; $display("FAIL legal_opcode: got %b want 100", cmd_opcode); end
        n_cmp++; if (cmd_payload !== 32'h0001_0000) begin n_bad++; $display("FAIL legal_payload: got %h want 00010000", cmd_payload); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after: got %b want 0", busy); end
    endtask

    task automatic test_bad_length(input logic [63:0] data, input int n);
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        start_frame();
        send_bits(data, n, 1'b0);
        end_frame();
        tick(12);
        n_cmp++; if (n_err - e0 != 1) begin n_bad++; $display("FAIL bad%0d_err_cnt: got %0d want 1", n, n_err - e0); end
        n_cmp++; if (n_valid - v0 != 0) begin n_bad++; $display("FAIL bad%0d_valid_cnt: got %0d want 0", n, n_valid - v0); end
        n_cmp++; if (cmd_opcode !== 3'b100) begin n_bad++; $display("FAIL bad%0d_opcode: got %b want 100", n, cmd_opcode); end
        n_cmp++; if (cmd_payload !== 32'h0001_0000) begin n_bad++; $display("FAIL bad%0d_payload: got %h want 00010000", n, cmd_payload); end
    endtask

    task automatic test_running(input logic [2:0] op, input logic [31:0] pay, input logic exp_run);
        start_frame();
        send_bits(64'({op, pay}), 35, 1'b0);
        end_frame();
        tick(12);
        n_cmp++; if (running !== exp_run) begin n_bad++; $display("FAIL run_op%b: got %b want %b", op, running, exp_run); end
        n_cmp++; if (cmd_opcode !== op) begin n_bad++; $display("FAIL run_opcode%b: got %b want %b", op, cmd_opcode, op); end
        n_cmp++; if (cmd_payload !== pay) begin n_bad++; $display("FAIL run_payload%b: got %h want %h", op, cmd_payload, pay); end
    endtask

    task automatic test_reset_midframe();
        int v0, e0;
        start_frame();
        send_bits(64'h2AA, 10, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(2);
        n_cmp++; if (cmd_payload !== 32'h0) begin n_bad++; $display("FAIL midrst_payload: got %h want 0", cmd_payload); end
        n_cmp++; if (cmd_opcode !== 3'b110) begin n_bad++; $display("FAIL midrst_opcode: got %b want 110", cmd_opcode); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rst = 1'b0;
        v0 = n_valid; e0 = n_err;
        send_bits(64'h1FF_FFFF, 25, 1'b0);
        end_frame();
        tick(12);
        n_cmp++; if (n_err - e0 != 1) begin n_bad++; $display("FAIL midrst_err_cnt: got %0d want 1", n_err - e0); end
        n_cmp++; if (n_valid - v0 != 0) begin n_bad++; $display("FAIL midrst_valid_cnt: got %0d want 0", n_valid - v0); end
        v0 = n_valid;
        start_frame();
        send_bits(64'({3'b000, 32'hABCD_1234}), 35, 1'b0);
        end_frame();
        tick(12);
        n_cmp++; if (n_valid - v0 != 1) begin n_bad++; $display("FAIL clean_valid_cnt: got %0d want 1", n_valid - v0); end
        n_cmp++; if (cmd_opcode !== 3'b000) begin n_bad++; $display("FAIL clean_opcode: got %b want 000", cmd_opcode); end
        n_cmp++; if (cmd_payload !== 32'hABCD_1234) begin n_bad++; $display("FAIL clean_payload: got %h want abcd1234", cmd_payload); end
    endtask

    task automatic test_coincident();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        start_frame();
        send_bits(64'({3'b011, 32'h8000_0001}), 35, 1'b1);
        tick(12);
        n_cmp++; if (n_valid - v0 != 1) begin n_bad++; $display("FAIL coinc_valid_cnt: got %0d want 1", n_valid - v0); end
        n_cmp++; if (n_err - e0 != 0) begin n_bad++; $display("FAIL coinc_err_cnt: got %0d want 0", n_err - e0); end
        n_cmp++; if (cmd_payload !== 32'h8000_0001) begin n_bad++; $display("FAIL coinc_payload: got %h want 80000001", cmd_payload); end
        n_cmp++; if (cmd_opcode !== 3'b011) begin n_bad++; $display("FAIL coinc_opcode: got %b want 011", cmd_opcode); end
    endtask

    task automatic test_zero_bit();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        start_frame();
        end_frame();
        tick(12);
        n_cmp++; if (n_err - e0 != 1) begin n_bad++; $display("FAIL zero_err_cnt: got %0d want 1", n_err - e0); end
        n_cmp++; if (n_valid - v0 != 0) begin n_bad++; $display("FAIL zero_valid_cnt: got %0d want 0", n_valid - v0); end
    endtask

    task automatic test_back_to_back();
        int v0, e0, q0;
        v0 = n_valid; e0 = n_err; q0 = q_pay.size();
        start_frame();
        send_bits(64'({3'b101, 32'h1234_5678}), 35, 1'b0);
        end_frame();
        tick(1);
        cs_n = 1'b0;
        tick(3);
        send_bits(64'({3'b001, 32'hCAFE_F00D}), 35, 1'b0);
        end_frame();
        tick(12);
        n_cmp++; if (n_valid - v0 != 2) begin n_bad++; $display("FAIL b2b_valid_cnt: got %0d want 2", n_valid - v0); end
        n_cmp++; if (n_err - e0 != 0) begin n_bad++; $display("FAIL b2b_err_cnt: got %0d want 0", n_err - e0); end
        if (q_pay.size() >= q0 + 2) begin
            n_cmp++; if (q_pay[q0] !== 32'h1234_5678) begin n_bad++; $display("FAIL b2b_pay0: got %h want 12345678", q_pay[q0]); end
            n_cmp++; if (q_op[q0] !== 3'b101) begin n_bad++; $display("FAIL b2b_op0: got %b want 101", q_op[q0]); end
            n_cmp++; if (q_pay[q0+1] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL b2b_pay1: got %h want cafef00d", q_pay[q0+1]); end
            n_cmp++; if (q_op[q0+1] !== 3'b001) begin n_bad++; $display("FAIL b2b_op1: got %b want 001", q_op[q0+1]); end
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL b2b_log: got %0d entries want %0d", q_pay.size() - q0, 2);
        end
    endtask

    initial begin
        test_reset();
        test_legal_frame();
        test_bad_length(64'h3_1234_5678, 34);
        test_bad_length(64'hF_FFFF_FFFF, 36);
        test_running(3'b111, 32'h0000_0001, 1'b1);
        test_running(3'b010, 32'h0000_0002, 1'b1);
        test_running(3'b110, 32'h0000_0003, 1'b0);
        test_reset_midframe();
        test_coincident();
        test_zero_bit();
        test_back_to_back();
        n_cmp++; if (n_both != 0) begin n_bad++; $display("FAIL valid_and_err: got %0d overlaps want 0", n_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
